// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU control sequencer and its opcode decoder.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ANDN = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_CMP  = 4'd8,
    OP_TST  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_N      = 3'd3,
    COND_NN     = 3'd4,
    COND_LE     = 3'd5,
    COND_GT     = 3'd6,
    COND_NEVER  = 3'd7
  } cond_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_AND   = 2'b01;
  localparam logic [1:0] ALUOP_XOR   = 2'b10;
  localparam logic [1:0] ALUOP_SHIFT = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       sub_shift_dir;
    logic       writeback;
    logic       legal;
  } dec_t;

  function automatic dec_t mk_dec(input logic [1:0] alu_op, input logic dir, input logic wb);
    dec_t d;
    d.alu_op        = alu_op;
    d.sub_shift_dir = dir;
    d.writeback     = wb;
    d.legal         = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: op -> ALU function select, sub/shift direction, writeback, legal.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] i_op,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_ADD:  o_dec = mk_dec(ALUOP_ADD,   1'b0, 1'b1);
      OP_SUB:  o_dec = mk_dec(ALUOP_ADD,   1'b1, 1'b1);
      OP_AND:  o_dec = mk_dec(ALUOP_AND,   1'b0, 1'b1);
      OP_ANDN: o_dec = mk_dec(ALUOP_AND,   1'b1, 1'b1);
      OP_XOR:  o_dec = mk_dec(ALUOP_XOR,   1'b0, 1'b1);
      OP_XNOR: o_dec = mk_dec(ALUOP_XOR,   1'b1, 1'b1);
      OP_SHR:  o_dec = mk_dec(ALUOP_SHIFT, 1'b0, 1'b1);
      OP_SHL:  o_dec = mk_dec(ALUOP_SHIFT, 1'b1, 1'b1);
      // Compare/test only update flags.
      OP_CMP:  o_dec = mk_dec(ALUOP_ADD,   1'b1, 1'b0);
      OP_TST:  o_dec = mk_dec(ALUOP_AND,   1'b0, 1'b0);
      default: o_dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: IDLE -> EXEC -> COMMIT, owns N/Z flags.
// Optional branch-condition evaluation enabled by defining ALU_SEQ_COND_EN.
module alu_ctrl_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned REG_SEL_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [3:0]           i_op,
  input  logic [REG_SEL_W-1:0] i_srcA,
  input  logic [REG_SEL_W-1:0] i_srcB,
  input  logic [REG_SEL_W-1:0] i_dst,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_illegal,
  output logic [REG_SEL_W-1:0] o_rdSelA,
  output logic [REG_SEL_W-1:0] o_rdSelB,
  output logic                 o_regOe,
  output logic                 o_regWr,
  output logic [REG_SEL_W-1:0] o_wrSel,
  output logic [1:0]           o_aluOp,
  output logic                 o_aluSubShiftDir,
  output logic                 o_aluWr,
  output logic                 o_aluNoe,
  input  logic                 i_negative,
  input  logic                 i_zero,
  output logic                 o_flagN,
  output logic                 o_flagZ,
  input  logic [2:0]           i_cond,
  output logic                 o_condTrue
);

  state_t               state_q, state_d;
  dec_t                 dec;
  logic [1:0]           alu_op_q;
  logic                 sub_dir_q;
  logic                 wb_q;
  logic [REG_SEL_W-1:0] sel_a_q, sel_b_q, dst_q;
  logic                 flag_n_q, flag_z_q;
  logic                 illegal_q;
  logic                 accept, reject;

  alu_op_decode u_decode (
    .i_op  (i_op),
    .o_dec (dec)
  );

  // COMMIT can accept the next instruction, giving 2-cycle throughput.
  assign o_ready = (state_q != EXEC);
  assign accept  = o_ready & i_start & dec.legal;
  assign reject  = o_ready & i_start & ~dec.legal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = COMMIT;
      COMMIT:  state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      alu_op_q  <= '0;
      sub_dir_q <= 1'b0;
      wb_q      <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      dst_q     <= '0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= reject;
      if (state_q == COMMIT) begin
        flag_n_q <= i_negative;
        flag_z_q <= i_zero;
      end
      if (accept) begin
        alu_op_q  <= dec.alu_op;
        sub_dir_q <= dec.sub_shift_dir;
        wb_q      <= dec.writeback;
        sel_a_q   <= i_srcA;
        sel_b_q   <= i_srcB;
        dst_q     <= i_dst;
      end
    end
  end

  assign o_done           = (state_q == COMMIT);
  assign o_illegal        = illegal_q;
  assign o_rdSelA         = sel_a_q;
  assign o_rdSelB         = sel_b_q;
  assign o_regOe          = (state_q == EXEC);
  assign o_aluWr          = (state_q == EXEC);
  // ALU drives the bus only while the register file is off it.
  assign o_aluNoe         = (state_q != COMMIT);
  assign o_regWr          = (state_q == COMMIT) & wb_q;
  assign o_wrSel          = dst_q;
  assign o_aluOp          = alu_op_q;
  assign o_aluSubShiftDir = sub_dir_q;
  assign o_flagN          = flag_n_q;
  assign o_flagZ          = flag_z_q;

`ifdef ALU_SEQ_COND_EN
  always_comb begin
    o_condTrue = 1'b0;
    case (cond_t'(i_cond))
      COND_ALWAYS: o_condTrue = 1'b1;
      COND_Z:      o_condTrue = flag_z_q;
      COND_NZ:     o_condTrue = ~flag_z_q;
      COND_N:      o_condTrue = flag_n_q;
      COND_NN:     o_condTrue = ~flag_n_q;
      COND_LE:     o_condTrue = flag_n_q | flag_z_q;
      COND_GT:     o_condTrue = ~(flag_n_q | flag_z_q);
      COND_NEVER:  o_condTrue = 1'b0;
      default:     o_condTrue = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^i_cond;
  assign o_condTrue  = 1'b0;
`endif

endmodule
